hpu_lsu_agu: RTL
================

# hpu_lsu_agu

Address-generation stage of the HPU load/store pipe. Sits directly downstream of the LSU operand-bypass stage: takes resolved rs1/rs2 operands plus the decoded immediate, computes the effective address, byte enables and aligned store data, and registers one request toward the data-cache port under a valid/ready handshake. It detects misaligned accesses and, when configured, splits them into two aligned beats.

## Interface
- DATA_W, 32, operand/address width (fixed byte lanes = DATA_W/8 = 4)
- PHY_IDX_W, 6, physical destination register index width
- ROB_IDX_W, 6, ROB tag width
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; kills the held request and any split in progress
- issue_valid_i  in  1  operation presented by bypass stage
- issue_ready_o  out  1  stage accepts operation this cycle
- issue_is_store_i  in  1  1 = store, 0 = load
- issue_size_i  in  2  0 byte, 1 half, 2 word (3 illegal, treated as word)
- issue_rs1_data_i  in  DATA_W  base, from bypass stage
- issue_rs2_data_i  in  DATA_W  store data, from bypass stage
- issue_imm_i  in  DATA_W  sign-extended offset
- issue_rdst_index_i  in  PHY_IDX_W  load destination
- issue_rob_id_i  in  ROB_IDX_W  ROB tag
- req_valid_o  out  1  request held
- req_ready_i  in  1  cache accepts request
- req_addr_o  out  DATA_W  word-aligned address
- req_we_o  out  1  write enable
- req_be_o  out  4  byte enables
- req_wdata_o  out  DATA_W  lane-aligned store data
- req_rdst_index_o / req_rob_id_o  out  PHY_IDX_W / ROB_IDX_W  tags passed through
- req_misalign_o  out  1  misaligned-access exception marker
- req_last_o  out  1  final beat of this operation

## Operation
- ea = rs1 + imm, modulo 2^DATA_W (no overflow detection). off = ea[1:0]. req_addr = {ea[31:2],2'b00}.
- Base enables: byte 0001, half 0011, word 1111; be = base << off (truncated to 4 bits). wdata = rs2 << 8·off.
- Misaligned: half with off=3, word with off≠0.
- Output register accepts when empty or drained this cycle: issue_ready_o = state==IDLE && !flush_i && (!req_valid_o || req_ready_i).
- Aligned op: loads register, req_last=1, req_misalign=0.
- Held request is stable (all req_* unchanged) while req_valid_o && !req_ready_i.
- States: IDLE, SPLIT_HI (only with split enabled). IDLE→SPLIT_HI on accepting a misaligned op; low beat loaded (be = (base<<off)[3:0], wdata = rs2<<8·off, last=0), upper bits of be/shift saved. SPLIT_HI: when low beat handshakes, register loads high beat: addr = req_addr+4 (wraps 0xFFFFFFFC→0x00000000), be = base>>(4−off), wdata = rs2>>(32−8·off), last=1; →IDLE on that load.
- Flush: next cycle req_valid_o=0, state=IDLE; a handshake coinciding with flush still completes at the cache, but no further beat is produced. Issue not accepted during flush cycle.
- Tags identical on both beats.

## Timing
- Latency 1: op accepted at cycle N → req_valid_o at N+1.
- Full throughput for aligned ops with req_ready_i held high (back-to-back accept).
- Split op occupies 2 output cycles minimum; issue_ready_o low from accept until high beat is loaded.
- Reset: req_valid_o=0, state IDLE, req_addr_o/req_wdata_o=0, req_be_o=0, req_we_o=0, req_misalign_o=0, req_last_o=0, tags 0; issue_ready_o=1 after reset deasserts. Reset overrides flush and handshake.

## Configuration
- HPU_LSU_MISALIGN_SPLIT_EN defined: misaligned ops split into two aligned beats as above; req_misalign_o always 0.
- Undefined: no SPLIT_HI state; misaligned op emits a single beat with req_misalign_o=1, req_be_o=0, req_we_o=0, req_last_o=1 (ROB raises exception).

## Test plan
- Aligned word load rs1=0x1000, imm=0x10, ready=1 → next cycle addr 0x1010, be 1111, we 0, last 1; second op accepted same cycle.
- Byte store rs1=0x2003, imm=0, rs2=0xAB, ready=0 for 3 cycles → addr 0x2000, be 1000, wdata 0xAB000000, held stable, issue_ready_o=0 until ready.
- Split on: word store ea=0x3002, rs2=0x11223344 → beat 1 addr 0x3000 be 1100 wdata 0x33440000 last 0; beat 2 addr 0x3004 be 0011 wdata 0x00001122 last 1.
- Split on: half load ea=0xFFFFFFFF → beat 1 addr 0xFFFFFFFC be 1000; beat 2 addr 0x00000000 be 0001.
- Split off: word load ea=0x4001 → single beat misalign 1, be 0000, last 1.
- Flush asserted while beat 1 stalled (ready=0) → req_valid_o=0 next cycle, no high beat, issue_ready_o=1 the cycle after flush.

Source files
------------

// File: rtl/hpu_lsu_agu.sv
// Address-generation stage of the HPU load/store pipe: effective address, byte enables, lane-aligned store data.
// Optional macro HPU_LSU_MISALIGN_SPLIT_EN splits misaligned accesses into two aligned beats instead of flagging them.
module hpu_lsu_agu #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned PHY_IDX_W = 6,
   parameter int unsigned ROB_IDX_W = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 issue_valid_i,
   output logic                 issue_ready_o,
   input  logic                 issue_is_store_i,
   input  logic [1:0]           issue_size_i,
   input  logic [DATA_W-1:0]    issue_rs1_data_i,
   input  logic [DATA_W-1:0]    issue_rs2_data_i,
   input  logic [DATA_W-1:0]    issue_imm_i,
   input  logic [PHY_IDX_W-1:0] issue_rdst_index_i,
   input  logic [ROB_IDX_W-1:0] issue_rob_id_i,
   output logic                 req_valid_o,
   input  logic                 req_ready_i,
   output logic [DATA_W-1:0]    req_addr_o,
   output logic                 req_we_o,
   output logic [3:0]           req_be_o,
   output logic [DATA_W-1:0]    req_wdata_o,
   output logic [PHY_IDX_W-1:0] req_rdst_index_o,
   output logic [ROB_IDX_W-1:0] req_rob_id_o,
   output logic                 req_misalign_o,
   output logic                 req_last_o
);

   logic                 reqValid_q, reqValid_d;
   logic [DATA_W-1:0]    reqAddr_q, reqAddr_d;
   logic                 reqWe_q, reqWe_d;
   logic [3:0]           reqBe_q, reqBe_d;
   logic [DATA_W-1:0]    reqWdata_q, reqWdata_d;
   logic [PHY_IDX_W-1:0] reqRdst_q, reqRdst_d;
   logic [ROB_IDX_W-1:0] reqRob_q, reqRob_d;
   logic                 reqMisalign_q, reqMisalign_d;
   logic                 reqLast_q, reqLast_d;

   logic [DATA_W-1:0]    effAddr;
   logic [1:0]           off;
   logic [3:0]           baseBe;
   logic [3:0]           loBe;
   logic [DATA_W-1:0]    loData;
   logic                 misaligned;
   logic                 issueReady;
   logic                 accept;

`ifdef HPU_LSU_MISALIGN_SPLIT_EN
   typedef enum logic {IDLE, SPLIT_HI} state_t;
   state_t               state_q, state_d;
   logic [3:0]           hiBe_q, hiBe_d;
   logic [DATA_W-1:0]    hiWdata_q, hiWdata_d;
   logic [3:0]           hiBe;
   logic [DATA_W-1:0]    hiData;
`endif

   always_comb begin
      effAddr = issue_rs1_data_i + issue_imm_i;
      off     = effAddr[1:0];
      case (issue_size_i)
         2'd0:    baseBe = 4'b0001;
         2'd1:    baseBe = 4'b0011;
         default: baseBe = 4'b1111;
      endcase
      loBe       = baseBe << off;
      loData     = issue_rs2_data_i << {off, 3'b000};
      misaligned = ((issue_size_i == 2'd1) && (off == 2'd3)) ||
                   (issue_size_i[1] && (off != 2'd0));
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
      // Only meaningful when misaligned, so off is never zero here.
      hiBe   = baseBe >> (3'd4 - {1'b0, off});
      hiData = issue_rs2_data_i >> (6'd32 - {1'b0, off, 3'b000});
      issueReady = (state_q == IDLE) && !flush_i && (!reqValid_q || req_ready_i);
`else
      issueReady = !flush_i && (!reqValid_q || req_ready_i);
`endif
      accept = issue_valid_i && issueReady;
   end

   always_comb begin
      reqValid_d    = reqValid_q;
      reqAddr_d     = reqAddr_q;
      reqWe_d       = reqWe_q;
      reqBe_d       = reqBe_q;
      reqWdata_d    = reqWdata_q;
      reqRdst_d     = reqRdst_q;
      reqRob_d      = reqRob_q;
      reqMisalign_d = reqMisalign_q;
      reqLast_d     = reqLast_q;
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
      state_d       = state_q;
      hiBe_d        = hiBe_q;
      hiWdata_d     = hiWdata_q;
`endif
      // Flush drops the held beat; a coincident handshake has already reached the cache.
      if (flush_i) begin
         reqValid_d = 1'b0;
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
         state_d    = IDLE;
`endif
      end
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
      else if (state_q == SPLIT_HI) begin
         if (req_ready_i) begin
            reqAddr_d  = reqAddr_q + DATA_W'(4);
            reqBe_d    = hiBe_q;
            reqWdata_d = hiWdata_q;
            reqLast_d  = 1'b1;
            state_d    = IDLE;
         end
      end
`endif
      else if (accept) begin
         reqValid_d    = 1'b1;
         reqAddr_d     = {effAddr[DATA_W-1:2], 2'b00};
         reqWe_d       = issue_is_store_i;
         reqBe_d       = loBe;
         reqWdata_d    = loData;
         reqRdst_d     = issue_rdst_index_i;
         reqRob_d      = issue_rob_id_i;
         reqMisalign_d = 1'b0;
         reqLast_d     = 1'b1;
         if (misaligned) begin
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
            reqLast_d = 1'b0;
            hiBe_d    = hiBe;
            hiWdata_d = hiData;
            state_d   = SPLIT_HI;
`else
            reqMisalign_d = 1'b1;
            reqBe_d       = 4'b0000;
            reqWe_d       = 1'b0;
`endif
         end
      end else if (req_ready_i) begin
         reqValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         reqValid_q    <= 1'b0;
         reqAddr_q     <= '0;
         reqWe_q       <= 1'b0;
         reqBe_q       <= 4'b0000;
         reqWdata_q    <= '0;
         reqRdst_q     <= '0;
         reqRob_q      <= '0;
         reqMisalign_q <= 1'b0;
         reqLast_q     <= 1'b0;
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
         state_q       <= IDLE;
         hiBe_q        <= 4'b0000;
         hiWdata_q     <= '0;
`endif
      end else begin
         reqValid_q    <= reqValid_d;
         reqAddr_q     <= reqAddr_d;
         reqWe_q       <= reqWe_d;
         reqBe_q       <= reqBe_d;
         reqWdata_q    <= reqWdata_d;
         reqRdst_q     <= reqRdst_d;
         reqRob_q      <= reqRob_d;
         reqMisalign_q <= reqMisalign_d;
         reqLast_q     <= reqLast_d;
`ifdef HPU_LSU_MISALIGN_SPLIT_EN
         state_q       <= state_d;
         hiBe_q        <= hiBe_d;
         hiWdata_q     <= hiWdata_d;
`endif
      end
   end

   assign issue_ready_o    = issueReady;
   assign req_valid_o      = reqValid_q;
   assign req_addr_o       = reqAddr_q;
   assign req_we_o         = reqWe_q;
   assign req_be_o         = reqBe_q;
   assign req_wdata_o      = reqWdata_q;
   assign req_rdst_index_o = reqRdst_q;
   assign req_rob_id_o     = reqRob_q;
   assign req_misalign_o   = reqMisalign_q;
   assign req_last_o       = reqLast_q;

endmodule
